// File: rtl/dmac_ahb_pkg.sv
// Shared AHB encodings and byte-lane helper for the DMAC memory slave.
package dmac_ahb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RespOkay  = 2'b00,
        RespError = 2'b01,
        RespRetry = 2'b10,
        RespSplit = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        SizeByte = 3'b000,
        SizeHalf = 3'b001,
        SizeWord = 3'b010
    } hsize_e;

    // Little-endian lane enables for a legal, aligned transfer.
    function automatic logic [3:0] byte_en(hsize_e size, logic [1:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SizeByte: be = 4'b0001 << addr;
            SizeHalf: be = addr[1] ? 4'b1100 : 4'b0011;
            SizeWord: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmac_mem_bytewr_ram.sv
// Word-organised RAM: one synchronous byte-enable write port, one asynchronous read port.
module dmac_mem_bytewr_ram #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned AddrW     = $clog2(MEM_DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmac_ahb_mem_slave.sv
// AHB memory slave: address-phase decode, wait-state/error FSM, saturating error counter
// in front of a byte-writable word RAM.
module dmac_ahb_mem_slave
    import dmac_ahb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hrst_n,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic [1:0]  hresp,
    output logic [15:0] err_cnt
);

    localparam int unsigned AW = $clog2(4 * MEM_DEPTH);
    localparam logic [3:0] WaitLast = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e         state_q;
    logic [3:0]     wcnt_q;
    logic [AW-1:0]  addr_q;
    logic [2:0]     size_q;
    logic           write_q;
    logic           hready_q;
    logic [1:0]     hresp_q;
    logic [15:0]    err_cnt_q;

    logic           accept;
    logic           in_win;
    logic           bad_size;
    logic           xfer_err;
    logic           mem_we;
    logic [3:0]     mem_be;
    logic [31:0]    mem_rdata;
    logic           unused_inputs;

    assign unused_inputs = ^{hburst, hprot, htrans[0]};

    always_comb begin
        accept = hready_q & hsel & htrans[1];
        // Window is aligned to its size, so only the upper address bits need comparing.
        in_win = (haddr[31:AW] == BASE_ADDR[31:AW]);
        case (hsize)
            3'b000:  bad_size = 1'b0;
            3'b001:  bad_size = haddr[0];
            3'b010:  bad_size = |haddr[1:0];
            default: bad_size = 1'b1;
        endcase
        xfer_err = ~in_win | bad_size;
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q  <= StIdle;
            wcnt_q   <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= RespOkay;
        end else begin
            if (accept) begin
                addr_q  <= haddr[AW-1:0];
                size_q  <= hsize;
                write_q <= hwrite;
            end
            case (state_q)
                StWait: begin
                    if (wcnt_q == 4'd0) begin
                        state_q  <= StData;
                        hready_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                StErr1: begin
                    state_q  <= StErr2;
                    hready_q <= 1'b1;
                end
                // Idle, Data and Err2 all present hready=1 and may take a new beat.
                default: begin
                    if (!accept) begin
                        state_q  <= StIdle;
                        hready_q <= 1'b1;
                        hresp_q  <= RespOkay;
                    end else if (xfer_err) begin
                        state_q  <= StErr1;
                        hready_q <= 1'b0;
                        hresp_q  <= RespError;
                    end else if (WAIT_STATES == 0) begin
                        state_q  <= StData;
                        hready_q <= 1'b1;
                        hresp_q  <= RespOkay;
                    end else begin
                        state_q  <= StWait;
                        wcnt_q   <= WaitLast;
                        hready_q <= 1'b0;
                        hresp_q  <= RespOkay;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            err_cnt_q <= '0;
        end else if (state_q == StErr2 && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign mem_we = (state_q == StData) & write_q;
    assign mem_be = byte_en(hsize_e'(size_q), addr_q[1:0]);

    dmac_mem_bytewr_ram #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk_i   (hclk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (addr_q[AW-1:2]),
        .wdata_i (hwdata),
        .rdata_o (mem_rdata)
    );

    assign hrdata  = (state_q == StData && !write_q) ? mem_rdata : 32'h0;
    assign hready  = hready_q;
    assign hresp   = hresp_q;
    assign err_cnt = err_cnt_q;

endmodule
